// File: rtl/pxs_ball_motion_pkg.sv
// rtl/pxs_ball_motion_pkg.sv - shared stream field macros, state and direction encodings for the ball motion block
//
// Purpose : stream field layout of the 26-bit pixel stream (`VGA, `RGB, `XC, `YC)
//           plus FSM state and axis direction encodings used by pxs_ball_motion
//           and pxs_ball_axis.
// Ports   : none (package).
// Options : none; PXS_BALL_PAUSE_EN is consumed by pxs_ball_motion only.

`ifndef PXS_VH
`define PXS_VH
`define VGA 25:24
`define RGB 23:20
`define XC  19:10
`define YC  9:0
`endif

package pxs_ball_motion_pkg;

  localparam int STREAM_W = 26;
  localparam int POS_W    = 10;

  // SERVE holds the ball at centre while the serve countdown runs.
  typedef enum logic {
    ST_SERVE = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Forward is RIGHT on X and DOWN on Y; back is LEFT / UP.
  typedef enum logic {
    DIR_FWD  = 1'b0,
    DIR_BACK = 1'b1
  } dir_e;

endpackage

// File: rtl/pxs_ball_axis.sv
// rtl/pxs_ball_axis.sv - single-axis step, clamp and bounce unit
//
// Purpose : moves one coordinate by STEP per step_i, clamping to [0, LIMIT]
//           and reversing direction with a one-cycle bounce pulse at a wall.
// Ports   : clk_i     pixel clock
//           rst_ni    asynchronous active-low reset
//           restart_i return to INIT heading forward (wins over step_i)
//           step_i    apply one motion step this edge
//           pos_o     current position
//           dir_o     current direction (DIR_FWD / DIR_BACK)
//           bounce_o  high for the cycle after a wall hit

module pxs_ball_axis
  import pxs_ball_motion_pkg::*;
#(
  parameter int STEP  = 2,
  parameter int LIMIT = 624,
  parameter int INIT  = 312
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             restart_i,
  input  logic             step_i,
  output logic [POS_W-1:0] pos_o,
  output dir_e             dir_o,
  output logic             bounce_o
);

  localparam logic [POS_W:0]   STEP_W  = (POS_W+1)'(STEP);
  localparam logic [POS_W:0]   LIMIT_W = (POS_W+1)'(LIMIT);
  localparam logic [POS_W-1:0] INIT_W  = POS_W'(INIT);

  logic [POS_W-1:0] pos_q, pos_d;
  dir_e             dir_q, dir_d;
  logic             bounce_q, bounce_d;
  logic [POS_W:0]   pos_ext;
  logic [POS_W:0]   pos_fwd;

  // One extra bit so the forward sum can never wrap before the clamp test.
  assign pos_ext = {1'b0, pos_q};
  assign pos_fwd = pos_ext + STEP_W;

  always_comb begin
    pos_d    = pos_q;
    dir_d    = dir_q;
    bounce_d = 1'b0;
    if (restart_i) begin
      pos_d = INIT_W;
      dir_d = DIR_FWD;
    end else if (step_i) begin
      if (dir_q == DIR_FWD) begin
        if (pos_fwd >= LIMIT_W) begin
          pos_d    = LIMIT_W[POS_W-1:0];
          dir_d    = DIR_BACK;
          bounce_d = 1'b1;
        end else begin
          pos_d = pos_fwd[POS_W-1:0];
        end
      end else begin
        if (pos_ext <= STEP_W) begin
          pos_d    = '0;
          dir_d    = DIR_FWD;
          bounce_d = 1'b1;
        end else begin
          pos_d = pos_q - STEP_W[POS_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q    <= INIT_W;
      dir_q    <= DIR_FWD;
      bounce_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      bounce_q <= bounce_d;
    end
  end

  assign pos_o    = pos_q;
  assign dir_o    = dir_q;
  assign bounce_o = bounce_q;

endmodule

// File: rtl/pxs_ball_motion.sv
// rtl/pxs_ball_motion.sv - per-frame ball position generator feeding the ball overlay stage
//
// Purpose : detects one frame tick per frame (first line with YC == V_ACTIVE),
//           runs the SERVE/RUN FSM and steps the X/Y axes on that tick, and
//           forwards the pixel stream with one cycle of delay so stream and
//           position stay aligned downstream.
// Ports   : px_clk    pixel clock
//           reset_n   asynchronous active-low reset
//           RGBStr_i  pixel stream in;  RGBStr_o  same stream, 1 cycle later
//           enable    low: ticks ignored (no motion, serve count frozen)
//           restart   pulse: ball to centre, back to SERVE
//           pause     (PXS_BALL_PAUSE_EN only) high: ticks ignored
//           x_ball / y_ball      ball top-left position
//           bounce_x / bounce_y  one-cycle wall-hit pulses
//           serving   high while in SERVE
// Options : `define PXS_BALL_PAUSE_EN adds the pause input.

module pxs_ball_motion
  import pxs_ball_motion_pkg::*;
#(
  parameter int SIZE_BALL    = 16,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int STEP_X       = 2,
  parameter int STEP_Y       = 2,
  parameter int SERVE_FRAMES = 60
) (
  input  logic                px_clk,
  input  logic                reset_n,
  input  logic [STREAM_W-1:0] RGBStr_i,
  output logic [STREAM_W-1:0] RGBStr_o,
  input  logic                enable,
  input  logic                restart,
`ifdef PXS_BALL_PAUSE_EN
  input  logic                pause,
`endif
  output logic [POS_W-1:0]    x_ball,
  output logic [POS_W-1:0]    y_ball,
  output logic                bounce_x,
  output logic                bounce_y,
  output logic                serving
);

  localparam int XC0  = (H_ACTIVE - SIZE_BALL) / 2;
  localparam int YC0  = (V_ACTIVE - SIZE_BALL) / 2;
  localparam int XMAX = H_ACTIVE - SIZE_BALL;
  localparam int YMAX = V_ACTIVE - SIZE_BALL;

  localparam logic [POS_W-1:0] V_TRIG   = POS_W'(V_ACTIVE);
  localparam logic [7:0]       SERVE_LD = 8'(SERVE_FRAMES);

  logic [STREAM_W-1:0] stream_q;
  logic [POS_W-1:0]    yc_q;
  state_e              state_q, state_d;
  logic [7:0]          serve_cnt_q, serve_cnt_d;
  logic                tick;
  logic                tick_ok;
  logic                frame_ev;
  logic                step;
  dir_e                dir_x, dir_y;

  // Rising edge of "YC is on the trigger line": one tick per frame no matter
  // how many cycles YC sits at V_ACTIVE.
  assign tick = (RGBStr_i[`YC] == V_TRIG) && (yc_q != V_TRIG);

`ifdef PXS_BALL_PAUSE_EN
  assign tick_ok = enable && !pause;
`else
  assign tick_ok = enable;
`endif

  assign frame_ev = tick && tick_ok;
  assign step     = frame_ev && (state_q == ST_RUN) && !restart;

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    if (restart) begin
      state_d     = ST_SERVE;
      serve_cnt_d = SERVE_LD;
    end else if (frame_ev && (state_q == ST_SERVE)) begin
      // The last serve tick only hands over to RUN; the ball first moves on
      // the following tick.
      serve_cnt_d = serve_cnt_q - 8'd1;
      if (serve_cnt_q == 8'd1) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      stream_q    <= '0;
      yc_q        <= '0;
      state_q     <= ST_SERVE;
      serve_cnt_q <= SERVE_LD;
    end else begin
      stream_q    <= RGBStr_i;
      yc_q        <= RGBStr_i[`YC];
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
    end
  end

  pxs_ball_axis #(
    .STEP  (STEP_X),
    .LIMIT (XMAX),
    .INIT  (XC0)
  ) u_axis_x (
    .clk_i     (px_clk),
    .rst_ni    (reset_n),
    .restart_i (restart),
    .step_i    (step),
    .pos_o     (x_ball),
    .dir_o     (dir_x),
    .bounce_o  (bounce_x)
  );

  pxs_ball_axis #(
    .STEP  (STEP_Y),
    .LIMIT (YMAX),
    .INIT  (YC0)
  ) u_axis_y (
    .clk_i     (px_clk),
    .rst_ni    (reset_n),
    .restart_i (restart),
    .step_i    (step),
    .pos_o     (y_ball),
    .dir_o     (dir_y),
    .bounce_o  (bounce_y)
  );

  // Directions are internal state only; the overlay needs just the position.
  logic unused_dir;
  assign unused_dir = dir_x ^ dir_y;

  assign RGBStr_o = stream_q;
  assign serving  = (state_q == ST_SERVE);

endmodule

// File: tb/tb_pxs_ball_motion.sv
// tb/tb_pxs_ball_motion.sv - self-checking bench for pxs_ball_motion

module tb_pxs_ball_motion;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b1;
  logic        restart = 1'b0;
  logic        pause = 1'b0;
  logic [1:0]  vga_v = 2'b00;
  logic [3:0]  rgb_v = 4'h0;
  logic [9:0]  xc_v = 10'd0;
  logic [9:0]  yc_v = 10'd0;
  logic [25:0] str_i;

  logic [25:0] str_o, str5_o;
  logic [9:0]  x, y, x5, y5;
  logic        bx, by, sv, bx5, by5, sv5;

  int checks = 0;
  int errors = 0;

  assign str_i = {vga_v, rgb_v, xc_v, yc_v};

  always #5 clk = ~clk;

  pxs_ball_motion #(.SERVE_FRAMES(2)) dut (
    .px_clk   (clk),
    .reset_n  (rst_n),
    .RGBStr_i (str_i),
    .RGBStr_o (str_o),
    .enable   (enable),
    .restart  (restart),
`ifdef PXS_BALL_PAUSE_EN
    .pause    (pause),
`endif
    .x_ball   (x),
    .y_ball   (y),
    .bounce_x (bx),
    .bounce_y (by),
    .serving  (sv)
  );

  pxs_ball_motion #(.SERVE_FRAMES(2), .STEP_X(5)) dut5 (
    .px_clk   (clk),
    .reset_n  (rst_n),
    .RGBStr_i (str_i),
    .RGBStr_o (str5_o),
    .enable   (enable),
    .restart  (restart),
`ifdef PXS_BALL_PAUSE_EN
    .pause    (pause),
`endif
    .x_ball   (x5),
    .y_ball   (y5),
    .bounce_x (bx5),
    .bounce_y (by5),
    .serving  (sv5)
  );

  // One frame: YC at the trigger line for one cycle, then back to 0. On
  // return the outputs show the update made by that tick.
  task automatic tick();
    @(negedge clk) yc_v = 10'd480;
    @(negedge clk) yc_v = 10'd0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (x !== 10'd312) begin errors++; $display("FAIL reset_x: got %0d expected 312", x); end
    checks++; if (y !== 10'd232) begin errors++; $display("FAIL reset_y: got %0d expected 232", y); end
    checks++; if (sv !== 1'b1) begin errors++; $display("FAIL reset_serving: got %0b expected 1", sv); end
    checks++; if ({bx, by} !== 2'b00) begin errors++; $display("FAIL reset_bounce: got %b expected 00", {bx, by}); end
    checks++; if (str_o !== 26'd0) begin errors++; $display("FAIL reset_stream: got %h expected 0", str_o); end
  endtask

  task automatic test_pass_through();
    @(negedge clk) begin vga_v = 2'b11; rgb_v = 4'hA; xc_v = 10'd123; end
    @(negedge clk);
    checks++; if (str_o !== {2'b11, 4'hA, 10'd123, 10'd0}) begin errors++; $display("FAIL pass_through: got %h expected %h", str_o, {2'b11, 4'hA, 10'd123, 10'd0}); end
    vga_v = 2'b00; rgb_v = 4'h0; xc_v = 10'd0;
    @(negedge clk);
    checks++; if (str_o !== 26'd0) begin errors++; $display("FAIL pass_through_clear: got %h expected 0", str_o); end
  endtask

  task automatic test_serve();
    do_reset();
    tick();
    checks++; if (sv !== 1'b1 || x !== 10'd312) begin errors++; $display("FAIL serve_tick1: serving %0b x %0d expected 1 312", sv, x); end
    tick();
    checks++; if (sv !== 1'b0 || x !== 10'd312 || y !== 10'd232) begin errors++; $display("FAIL serve_tick2: serving %0b x %0d y %0d expected 0 312 232", sv, x, y); end
    tick();
    checks++; if (x !== 10'd314 || y !== 10'd234) begin errors++; $display("FAIL first_move: x %0d y %0d expected 314 234", x, y); end
  endtask

  // Continues from test_serve: one RUN tick already applied.
  task automatic test_bounce();
    int bx_cnt = 0;
    int by_cnt = 0;
    for (int n = 2; n <= 157; n++) begin
      tick();
      bx_cnt += int'(bx);
      by_cnt += int'(by);
      if (n == 116) begin
        checks++; if (y !== 10'd464 || by !== 1'b1 || bx !== 1'b0) begin errors++; $display("FAIL bounce_y_hit: y %0d by %0b bx %0b expected 464 1 0", y, by, bx); end
        @(negedge clk);
        checks++; if (by !== 1'b0) begin errors++; $display("FAIL bounce_y_width: got %0b expected 0", by); end
      end
      if (n == 117) begin
        checks++; if (y !== 10'd462) begin errors++; $display("FAIL dir_y_up: got %0d expected 462", y); end
      end
      if (n == 156) begin
        checks++; if (x !== 10'd624 || bx !== 1'b1 || y !== 10'd384) begin errors++; $display("FAIL bounce_x_hit: x %0d bx %0b y %0d expected 624 1 384", x, bx, y); end
        @(negedge clk);
        checks++; if (bx !== 1'b0) begin errors++; $display("FAIL bounce_x_width: got %0b expected 0", bx); end
      end
      if (n == 157) begin
        checks++; if (x !== 10'd622 || y !== 10'd382) begin errors++; $display("FAIL dir_x_left: x %0d y %0d expected 622 382", x, y); end
      end
    end
    checks++; if (bx_cnt != 1 || by_cnt != 1) begin errors++; $display("FAIL bounce_count: bx %0d by %0d expected 1 1", bx_cnt, by_cnt); end
  endtask

  task automatic test_step5();
    do_reset();
    tick();
    tick();
    repeat (62) tick();
    checks++; if (x5 !== 10'd622 || bx5 !== 1'b0) begin errors++; $display("FAIL step5_pre: x %0d bx %0b expected 622 0", x5, bx5); end
    tick();
    checks++; if (x5 !== 10'd624 || bx5 !== 1'b1) begin errors++; $display("FAIL step5_clamp: x %0d bx %0b expected 624 1", x5, bx5); end
  endtask

  task automatic test_hold();
    do_reset();
    tick();
    tick();
    @(negedge clk) yc_v = 10'd480;
    repeat (800) @(negedge clk);
    yc_v = 10'd0;
    checks++; if (x !== 10'd314 || y !== 10'd234) begin errors++; $display("FAIL hold_one_update: x %0d y %0d expected 314 234", x, y); end
    tick();
    checks++; if (x !== 10'd316) begin errors++; $display("FAIL hold_next_tick: got %0d expected 316", x); end
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b0;
    repeat (3) tick();
    checks++; if (sv !== 1'b1 || x !== 10'd312) begin errors++; $display("FAIL enable_serve_frozen: serving %0b x %0d expected 1 312", sv, x); end
    enable = 1'b1;
    tick();
    checks++; if (sv !== 1'b1) begin errors++; $display("FAIL enable_count_kept: serving %0b expected 1", sv); end
    tick();
    checks++; if (sv !== 1'b0) begin errors++; $display("FAIL enable_to_run: serving %0b expected 0", sv); end
    tick();
    enable = 1'b0;
    repeat (3) tick();
    checks++; if (x !== 10'd314 || y !== 10'd234) begin errors++; $display("FAIL enable_run_frozen: x %0d y %0d expected 314 234", x, y); end
    enable = 1'b1;
  endtask

  task automatic test_restart();
    do_reset();
    tick();
    tick();
    repeat (44) tick();
    checks++; if (x !== 10'd400 || y !== 10'd320) begin errors++; $display("FAIL restart_pre: x %0d y %0d expected 400 320", x, y); end
    @(negedge clk) begin yc_v = 10'd480; restart = 1'b1; end
    @(negedge clk) begin yc_v = 10'd0; restart = 1'b0; end
    checks++; if (x !== 10'd312 || y !== 10'd232 || sv !== 1'b1) begin errors++; $display("FAIL restart_centre: x %0d y %0d serving %0b expected 312 232 1", x, y, sv); end
    tick();
    checks++; if (sv !== 1'b1 || x !== 10'd312) begin errors++; $display("FAIL restart_serve1: serving %0b x %0d expected 1 312", sv, x); end
    tick();
    checks++; if (sv !== 1'b0 || x !== 10'd312) begin errors++; $display("FAIL restart_serve2: serving %0b x %0d expected 0 312", sv, x); end
    tick();
    checks++; if (x !== 10'd314) begin errors++; $display("FAIL restart_move: got %0d expected 314", x); end
  endtask

  task automatic test_async_reset();
    @(negedge clk) rgb_v = 4'h5;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (x !== 10'd312 || y !== 10'd232) begin errors++; $display("FAIL async_reset_pos: x %0d y %0d expected 312 232", x, y); end
    checks++; if (str_o !== 26'd0 || sv !== 1'b1) begin errors++; $display("FAIL async_reset_stream: stream %h serving %0b expected 0 1", str_o, sv); end
    @(negedge clk) begin rst_n = 1'b1; rgb_v = 4'h0; end
  endtask

`ifdef PXS_BALL_PAUSE_EN
  task automatic test_pause();
    do_reset();
    tick();
    tick();
    tick();
    pause = 1'b1;
    repeat (5) tick();
    checks++; if (x !== 10'd314 || y !== 10'd234 || {bx, by} !== 2'b00) begin errors++; $display("FAIL pause_hold: x %0d y %0d expected 314 234", x, y); end
    pause = 1'b0;
    tick();
    checks++; if (x !== 10'd316 || y !== 10'd236) begin errors++; $display("FAIL pause_resume: x %0d y %0d expected 316 236", x, y); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pass_through();
    test_serve();
    test_bounce();
    test_step5();
    test_hold();
    test_enable();
    test_restart();
    test_async_reset();
`ifdef PXS_BALL_PAUSE_EN
    test_pause();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
